// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART transmit path.
//   tx_state_t      : transmit FSM states
//   OVERSAMPLE_DEF  : default BAUD_EN pulses per bit period
//   TICK_W / BIT_W  : widths of the tick counter and the data-bit index
//   calc_parity()   : parity bit over the 7 or 8 data bits actually sent
// ----------------------------------------------------------------------------
package uart_pkg;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int TICK_W         = 4;
    localparam int BIT_W          = 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } tx_state_t;

    // Bit 7 only contributes in 8-bit mode because it is never sent otherwise.
    function automatic logic calc_parity(input logic [7:0] data,
                                         input logic       bit8,
                                         input logic       odd_n_even);
        return (^data[6:0]) ^ (bit8 & data[7]) ^ odd_n_even;
    endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// ----------------------------------------------------------------------------
// uart_tx_bit_timer
// Counts BAUD_EN pulses and flags the pulse that completes one bit period.
//   i_clk       : system clock
//   i_rst_n     : synchronous reset, active low
//   i_clr       : hold the counter at zero (asserted while no bit is on the line)
//   i_baud_en   : x16 baud enable, counted once per CLK it is high
//   o_bit_done  : high in the cycle whose clock edge counts the last pulse
// ----------------------------------------------------------------------------
module uart_tx_bit_timer
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_baud_en,
    output logic o_bit_done
);

    logic [TICK_W-1:0] r_tick;
    logic              w_last_tick;

    assign w_last_tick = (r_tick == TICK_W'(OVERSAMPLE - 1));
    // The bit ends on the same edge the FSM moves on, so this flag is combinational.
    assign o_bit_done  = i_baud_en & ~i_clr & w_last_tick;

    // Tick counter: restarts at zero for every bit, so the next bit state starts clean.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_tick <= {TICK_W{1'b0}};
        end else if (i_clr) begin
            r_tick <= {TICK_W{1'b0}};
        end else if (i_baud_en) begin
            if (w_last_tick) begin
                r_tick <= {TICK_W{1'b0}};
            end else begin
                r_tick <= r_tick + {{(TICK_W-1){1'b0}}, 1'b1};
            end
        end else begin
            r_tick <= r_tick;
        end
    end

endmodule

// File: rtl/uart_tx_fifo_reader.sv
// ----------------------------------------------------------------------------
// uart_tx_fifo_reader
// Pops bytes from the TX FIFO read port and serialises them onto the TX line:
// start bit, 7/8 data bits LSB first, optional parity, stop bit(s).
// Optional build macro: UART_TX_2STOP_EN adds input STOP2 (two stop bits).
//   CLK         : system clock
//   RESET_N     : synchronous reset, active low
//   BAUD_EN     : one-CLK pulse at 16x baud
//   BIT8        : 1 = 8 data bits, 0 = 7 data bits
//   PARITY_EN   : insert parity bit
//   ODD_N_EVEN  : 1 = odd parity, 0 = even parity
//   STOP2       : (UART_TX_2STOP_EN only) 1 = stop lasts two bit periods
//   FIFO_EMPTY  : TX FIFO empty flag
//   FIFO_DATA   : FIFO registered read data
//   FIFO_RDB    : FIFO read strobe, active low, one CLK wide
//   TX          : serial line, idle high
//   TX_BUSY     : high from the read strobe until the end of the stop bit
// ----------------------------------------------------------------------------
module uart_tx_fifo_reader
    import uart_pkg::*;
#(
    parameter int FIFO_RD_LATENCY = 2,
    parameter int OVERSAMPLE      = OVERSAMPLE_DEF
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       BAUD_EN,
    input  logic       BIT8,
    input  logic       PARITY_EN,
    input  logic       ODD_N_EVEN,
`ifdef UART_TX_2STOP_EN
    input  logic       STOP2,
`endif
    input  logic       FIFO_EMPTY,
    input  logic [7:0] FIFO_DATA,
    output logic       FIFO_RDB,
    output logic       TX,
    output logic       TX_BUSY
);

    localparam logic [1:0] LAT = 2'(FIFO_RD_LATENCY);

    tx_state_t        r_state;
    logic [1:0]       r_lat;
    logic [BIT_W-1:0] r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_bit8;
    logic             r_par_en;
    logic             r_par_bit;
    logic             r_stop2;
    logic             r_stop_half;
    logic             r_tx;
    logic             r_rdb;
    logic             r_busy;

    logic             w_clr;
    logic             w_bit_done;
    logic             w_stop2;
    logic [BIT_W-1:0] w_last_idx;

`ifdef UART_TX_2STOP_EN
    assign w_stop2 = STOP2;
`else
    assign w_stop2 = 1'b0;
`endif

    // No bit is on the line in IDLE/FETCH, so BAUD_EN is ignored there.
    assign w_clr      = (r_state == IDLE) || (r_state == FETCH);
    assign w_last_idx = r_bit8 ? 3'd7 : 3'd6;

    assign FIFO_RDB = r_rdb;
    assign TX       = r_tx;
    assign TX_BUSY  = r_busy;

    uart_tx_bit_timer #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_bit_timer (
        .i_clk      (CLK),
        .i_rst_n    (RESET_N),
        .i_clr      (w_clr),
        .i_baud_en  (BAUD_EN),
        .o_bit_done (w_bit_done)
    );

    // Transmit FSM with shift register, frame configuration and registered outputs.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_state     <= IDLE;
            r_lat       <= 2'd0;
            r_bit_idx   <= {BIT_W{1'b0}};
            r_shift     <= 8'h00;
            r_bit8      <= 1'b0;
            r_par_en    <= 1'b0;
            r_par_bit   <= 1'b0;
            r_stop2     <= 1'b0;
            r_stop_half <= 1'b0;
            r_tx        <= 1'b1;
            r_rdb       <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_tx <= 1'b1;
                    if (!FIFO_EMPTY) begin
                        r_rdb   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_lat   <= 2'd0;
                        r_state <= FETCH;
                    end else begin
                        r_rdb  <= 1'b1;
                        r_busy <= 1'b0;
                    end
                end
                FETCH: begin
                    r_rdb <= 1'b1;
                    // Data is valid once the FIFO has seen the strobe plus its pipeline.
                    if (r_lat == LAT) begin
                        r_shift     <= FIFO_DATA;
                        r_bit8      <= BIT8;
                        r_par_en    <= PARITY_EN;
                        r_par_bit   <= calc_parity(FIFO_DATA, BIT8, ODD_N_EVEN);
                        r_stop2     <= w_stop2;
                        r_stop_half <= 1'b0;
                        r_bit_idx   <= {BIT_W{1'b0}};
                        r_tx        <= 1'b0;
                        r_state     <= START;
                    end else begin
                        r_lat <= r_lat + 2'd1;
                    end
                end
                START: begin
                    if (w_bit_done) begin
                        r_tx    <= r_shift[0];
                        r_shift <= {1'b0, r_shift[7:1]};
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    if (w_bit_done) begin
                        if (r_bit_idx == w_last_idx) begin
                            if (r_par_en) begin
                                r_tx    <= r_par_bit;
                                r_state <= PARITY;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= STOP;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_tx      <= r_shift[0];
                            r_shift   <= {1'b0, r_shift[7:1]};
                        end
                    end
                end
                PARITY: begin
                    if (w_bit_done) begin
                        r_tx    <= 1'b1;
                        r_state <= STOP;
                    end
                end
                STOP: begin
                    r_tx <= 1'b1;
                    if (w_bit_done) begin
                        // Two-stop frames run the bit timer through a second period.
                        if (r_stop2 && !r_stop_half) begin
                            r_stop_half <= 1'b1;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_rdb   <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
